// File: rtl/chirp_nco_pkg.sv
`default_nettype none
// ============================================================================
// Module  : chirp_nco_pkg
// Purpose : Shared definitions for the chirp NCO sample source. Contains the
//           default widths, the pipeline latency, the dither LFSR polynomial
//           and seed, the FSM state encoding and the quarter-wave sine ROM
//           generator that is evaluated at elaboration.
// Revision: 1.0 - initial release
// ============================================================================
package chirp_nco_pkg;

  localparam int DATA_WIDTH_DEF     = 18;
  localparam int PHASE_WIDTH_DEF    = 32;
  localparam int LUT_ADDR_WIDTH_DEF = 10;
  localparam int RATE_CNT_WIDTH_DEF = 16;

  // Clocks from a tick to the matching DataNd_o strobe
  localparam int PIPE_LAT = 3;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 (taps at bits 15,13,12,10)
  localparam int          LFSR_WIDTH = 16;
  localparam logic [15:0] LFSR_POLY  = 16'hB400;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Quarter-wave ROM entry j: round(A*sin(pi/2*(j+0.5)/N)), A = 2^(dw-1)-1.
  // The half-LSB index offset keeps every entry strictly positive and the
  // mirrored/negated quadrants exactly symmetric.
  function automatic int sine_rom_val(input int j, input int addr_w, input int data_w);
    real amp;
    real ang;
    amp = real'((1 << (data_w - 1)) - 1);
    ang = 3.14159265358979323846 / 2.0 * (real'(j) + 0.5) / real'(1 << addr_w);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage
`default_nettype wire

// File: rtl/chirp_nco_sine_lut.sv
`default_nettype none
// ============================================================================
// Module  : chirp_nco_sine_lut
// Purpose : Quarter-wave sine lookup with quadrant fold and output negation,
//           two registered stages (ROM read, signed output).
// Ports   : Clk_i   - clock
//           Rst_i   - synchronous active-high reset
//           Valid_i - phase word valid
//           Phase_i - {sign, mirror, index} taken from the phase MSBs
//           Data_o  - signed sample, held between strobes
//           Valid_o - one-cycle strobe, 2 clocks after Valid_i
// Revision: 1.0 - initial release
// ============================================================================
module chirp_nco_sine_lut
  import chirp_nco_pkg::*;
#(
  parameter int DataWidth    = DATA_WIDTH_DEF,
  parameter int LutAddrWidth = LUT_ADDR_WIDTH_DEF
) (
  input  logic                    Clk_i,
  input  logic                    Rst_i,
  input  logic                    Valid_i,
  input  logic [LutAddrWidth+1:0] Phase_i,
  output logic [DataWidth-1:0]    Data_o,
  output logic                    Valid_o
);

  localparam int Depth = 1 << LutAddrWidth;

  logic [DataWidth-2:0] rom_w [Depth];

  for (genvar j = 0; j < Depth; j++) begin : g_rom
    localparam int RomVal = sine_rom_val(j, LutAddrWidth, DataWidth);
    assign rom_w[j] = (DataWidth-1)'(RomVal);
  end

  logic                    sign_w;
  logic                    mirror_w;
  logic [LutAddrWidth-1:0] idx_w;

  assign sign_w   = Phase_i[LutAddrWidth+1];
  assign mirror_w = Phase_i[LutAddrWidth];
  // N-1-i is the bitwise complement of i for a power-of-two depth
  assign idx_w    = mirror_w ? ~Phase_i[LutAddrWidth-1:0] : Phase_i[LutAddrWidth-1:0];

  logic [DataWidth-2:0] mag_q;
  logic                 sign_q;
  logic                 vld_q;
  logic [DataWidth-1:0] data_q;
  logic                 nd_q;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      mag_q  <= '0;
      sign_q <= 1'b0;
      vld_q  <= 1'b0;
      data_q <= '0;
      nd_q   <= 1'b0;
    end else begin
      vld_q <= Valid_i;
      nd_q  <= vld_q;
      if (Valid_i) begin
        mag_q  <= rom_w[idx_w];
        sign_q <= sign_w;
      end
      // Magnitude is at most 2^(DataWidth-1)-1, so negation never reaches
      // the most negative code.
      if (vld_q) begin
        data_q <= sign_q ? -{1'b0, mag_q} : {1'b0, mag_q};
      end
    end
  end

  assign Data_o  = data_q;
  assign Valid_o = nd_q;

endmodule
`default_nettype wire

// File: rtl/chirp_nco_source.sv
`default_nettype none
// ============================================================================
// Module  : chirp_nco_source
// Purpose : Linear-FM (sawtooth chirp) sample source. Phase-accumulator NCO
//           feeding a quarter-wave sine ROM; one signed sample every
//           SamplePeriod_i clocks, frequency stepping by FreqStep_i per sample
//           and wrapping to FreqStart_i once it would exceed FreqStop_i.
// Ports   : Clk_i, Rst_i (sync, active high)
//           Start_i        - latch config and begin sweep (IDLE only)
//           Stop_i         - end sweep and drain pipeline (RUN only)
//           FreqStart_i    - initial phase increment
//           FreqStep_i     - increment added to frequency per sample
//           FreqStop_i     - sweep ceiling
//           SamplePeriod_i - clocks per sample (0 and 1 mean every clock)
//           Data_o         - signed sample, held between strobes
//           DataNd_o       - one-cycle new-data strobe
//           Busy_o         - high in RUN and DRAIN
// Options : CHIRP_NCO_DITHER_EN - LFSR phase dither below the ROM index.
//           Undefined: plain truncation, output bit-exact with the ROM.
// Revision: 1.0 - initial release
// ============================================================================
module chirp_nco_source
  import chirp_nco_pkg::*;
#(
  parameter int DataWidth    = DATA_WIDTH_DEF,
  parameter int PhaseWidth   = PHASE_WIDTH_DEF,
  parameter int LutAddrWidth = LUT_ADDR_WIDTH_DEF,
  parameter int RateCntWidth = RATE_CNT_WIDTH_DEF
) (
  input  logic                    Clk_i,
  input  logic                    Rst_i,
  input  logic                    Start_i,
  input  logic                    Stop_i,
  input  logic [PhaseWidth-1:0]   FreqStart_i,
  input  logic [PhaseWidth-1:0]   FreqStep_i,
  input  logic [PhaseWidth-1:0]   FreqStop_i,
  input  logic [RateCntWidth-1:0] SamplePeriod_i,
  output logic [DataWidth-1:0]    Data_o,
  output logic                    DataNd_o,
  output logic                    Busy_o
);

  state_e                  state_q;
  logic                    busy_q;
  logic                    arm_q;       // one cycle between Start and accumulator init
  logic [1:0]              drain_q;
  logic [RateCntWidth-1:0] cnt_q;
  logic [PhaseWidth-1:0]   phase_q;
  logic [PhaseWidth-1:0]   freq_q;
  logic [PhaseWidth-1:0]   freq_d;
  logic [PhaseWidth-1:0]   cfg_start_q;
  logic [PhaseWidth-1:0]   cfg_step_q;
  logic [PhaseWidth-1:0]   cfg_stop_q;
  logic [RateCntWidth-1:0] cfg_pm1_q;   // max(period,1)-1
  logic [LutAddrWidth+1:0] cap_q;
  logic [LutAddrWidth+1:0] cap_d;
  logic                    cap_vld_q;
  logic                    tick_w;
  logic [PhaseWidth:0]     freq_sum_w;

  assign tick_w = (state_q == ST_RUN) && !arm_q && (cnt_q == cfg_pm1_q);

  // Compare with the carry bit so an overflowing step still wraps the sweep
  assign freq_sum_w = {1'b0, freq_q} + {1'b0, cfg_step_q};
  assign freq_d     = (freq_sum_w > {1'b0, cfg_stop_q}) ? cfg_start_q
                                                        : freq_sum_w[PhaseWidth-1:0];

`ifdef CHIRP_NCO_DITHER_EN
  localparam int FracWidth = PhaseWidth - 2 - LutAddrWidth;

  logic [LFSR_WIDTH-1:0] lfsr_q;
  logic [PhaseWidth-1:0] dither_w;
  logic [PhaseWidth-1:0] dith_phase_w;

  // LFSR word aligned to the top of the fraction: uniform over one index LSB
  if (FracWidth >= LFSR_WIDTH) begin : g_dither_wide
    assign dither_w = PhaseWidth'(lfsr_q) << (FracWidth - LFSR_WIDTH);
  end else begin : g_dither_narrow
    assign dither_w = PhaseWidth'(lfsr_q >> (LFSR_WIDTH - FracWidth));
  end

  assign dith_phase_w = phase_q + dither_w;
  assign cap_d        = dith_phase_w[PhaseWidth-1 -: LutAddrWidth+2];

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (tick_w) begin
      lfsr_q <= {lfsr_q[LFSR_WIDTH-2:0], ^(lfsr_q & LFSR_POLY)};
    end
  end
`else
  assign cap_d = phase_q[PhaseWidth-1 -: LutAddrWidth+2];
`endif

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      arm_q       <= 1'b0;
      drain_q     <= '0;
      cnt_q       <= '0;
      phase_q     <= '0;
      freq_q      <= '0;
      cfg_start_q <= '0;
      cfg_step_q  <= '0;
      cfg_stop_q  <= '0;
      cfg_pm1_q   <= '0;
      cap_q       <= '0;
      cap_vld_q   <= 1'b0;
    end else begin
      cap_vld_q <= tick_w;
      if (tick_w) begin
        cap_q <= cap_d;
      end

      case (state_q)
        ST_IDLE: begin
          if (Start_i) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            arm_q       <= 1'b1;
            cfg_start_q <= FreqStart_i;
            cfg_step_q  <= FreqStep_i;
            cfg_stop_q  <= FreqStop_i;
            cfg_pm1_q   <= (SamplePeriod_i == '0) ? '0
                                                  : SamplePeriod_i - RateCntWidth'(1);
          end
        end

        ST_RUN: begin
          if (arm_q) begin
            arm_q   <= 1'b0;
            phase_q <= '0;
            freq_q  <= cfg_start_q;
            cnt_q   <= '0;
          end else if (tick_w) begin
            cnt_q   <= '0;
            phase_q <= phase_q + freq_q;
            freq_q  <= freq_d;
          end else begin
            cnt_q <= cnt_q + RateCntWidth'(1);
          end
          // A tick in the same cycle is still captured above
          if (Stop_i) begin
            state_q <= ST_DRAIN;
            drain_q <= '0;
          end
        end

        ST_DRAIN: begin
          if (drain_q == 2'(PIPE_LAT - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  chirp_nco_sine_lut #(
    .DataWidth   (DataWidth),
    .LutAddrWidth(LutAddrWidth)
  ) u_lut (
    .Clk_i  (Clk_i),
    .Rst_i  (Rst_i),
    .Valid_i(cap_vld_q),
    .Phase_i(cap_q),
    .Data_o (Data_o),
    .Valid_o(DataNd_o)
  );

  assign Busy_o = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_chirp_nco_source.sv
`default_nettype none
// ============================================================================
// Module  : tb_chirp_nco_source
// Purpose : Self-checking bench for chirp_nco_source (default build, no
//           dither). Table of sweep records plus randomized sweeps, each
//           checked cycle by cycle against a phase/frequency model that
//           computes samples directly from a full-circle sine.
// Revision: 1.0 - initial release
// ============================================================================
module tb_chirp_nco_source;

  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = 131071.0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [31:0] fstart;
  logic [31:0] fstep;
  logic [31:0] fstop;
  logic [15:0] per;
  logic [17:0] data;
  logic        nd;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] fs;
    logic [31:0] step;
    logic [31:0] stop;
    logic [15:0] per;
    int          nstop;      // index of the sample whose tick coincides with Stop
    bit          inject;     // pulse Start during RUN and DRAIN
    int          exp_first;  // expected first strobe, clocks after the Start edge
  } vec_t;

  vec_t vecs[$];
  int   got_q[$];

  chirp_nco_source dut (
    .Clk_i         (clk),
    .Rst_i         (rst),
    .Start_i       (start),
    .Stop_i        (stop),
    .FreqStart_i   (fstart),
    .FreqStep_i    (fstep),
    .FreqStop_i    (fstop),
    .SamplePeriod_i(per),
    .Data_o        (data),
    .DataNd_o      (nd),
    .Busy_o        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Sample for a 32-bit phase: 4096 equal bins around the circle, value
  // taken at the bin centre, rounded half away from zero.
  function automatic int model_sample(input longint ph);
    longint bin;
    real    r;
    bin = ph >> 20;
    r   = AMP * $sin(2.0 * PI * (real'(bin) + 0.5) / 4096.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  task automatic add_vec(input logic [31:0] fs, input logic [31:0] step, input logic [31:0] stp,
                         input logic [15:0] p, input int nstop, input bit inject, input int first);
    vec_t v;
    v.fs = fs; v.step = step; v.stop = stp; v.per = p;
    v.nstop = nstop; v.inject = inject; v.exp_first = first;
    vecs.push_back(v);
  endtask

  task automatic run_sweep(input vec_t v);
    longint ph;
    longint fr;
    int     p;
    int     jstop;
    int     n;
    int     first_j;
    int     expv;
    longint last;
    bit     exp_nd;
    p       = (v.per == 16'd0) ? 1 : int'(v.per);
    jstop   = p * (v.nstop + 1);
    ph      = 0;
    fr      = longint'(v.fs);
    n       = 0;
    first_j = -1;
    got_q.delete();

    @(negedge clk);
    fstart = v.fs; fstep = v.step; fstop = v.stop; per = v.per; start = 1'b1;
    @(negedge clk);
    // Config must have been latched; scramble the inputs
    start  = 1'b0;
    fstart = $urandom; fstep = $urandom; fstop = $urandom;
    per    = 16'($urandom_range(0, 40));
    last   = longint'($signed(data));

    for (int j = 1; j <= jstop + 8; j++) begin
      @(negedge clk);
      exp_nd = (n <= v.nstop) && (j == p + 3 + n * p);
      chk("strobe", longint'(nd), longint'(exp_nd));
      chk("busy", longint'(busy), longint'(j <= jstop + 3));
      if (exp_nd) begin
        if (first_j < 0) first_j = j;
        expv = model_sample(ph);
        got_q.push_back(int'($signed(data)));
        chk("sample", longint'($signed(data)), longint'(expv));
        last = longint'(expv);
        ph   = (ph + fr) % (longint'(1) << 32);
        if (fr + longint'(v.step) > longint'(v.stop)) fr = longint'(v.fs);
        else fr = fr + longint'(v.step);
        n++;
      end else begin
        chk("hold", longint'($signed(data)), last);
      end
      stop  = (j == jstop);
      start = v.inject && ((j == p + 1) || (j == jstop + 3));
    end
    stop  = 1'b0;
    start = 1'b0;
    chk("first_strobe", longint'(first_j), longint'(v.exp_first));

    // Stop in IDLE is ignored
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    chk("idle_stop_busy", longint'(busy), 0);
  endtask

  int sq_exp[4] = '{101, 131071, -101, -131071};
  int pre_cnt;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    fstart = '0; fstep = '0; fstop = '0; per = '0;
    repeat (3) @(negedge clk);
    chk("reset_data", longint'(data), 0);
    chk("reset_nd", longint'(nd), 0);
    chk("reset_busy", longint'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    //       FreqStart      FreqStep       FreqStop       P      nstop inj first
    add_vec(32'h4000_0000, 32'h0,         32'hFFFF_FFFF, 16'd1,  7,  0, 4);
    add_vec(32'h0123_4567, 32'h0010_0000, 32'h2000_0000, 16'd16, 2,  0, 19);
    add_vec(32'd100,       32'd50,        32'd250,       16'd2,  9,  0, 5);
    add_vec(32'd100 << 20, 32'd50 << 20,  32'd250 << 20, 16'd1,  11, 0, 4);
    add_vec(32'h0800_0000, 32'h0100_0000, 32'h3000_0000, 16'd8,  3,  0, 11);
    add_vec(32'h0555_5555, 32'h0040_0000, 32'h1000_0000, 16'd3,  5,  1, 6);
    add_vec(32'hF000_0000, 32'h2000_0000, 32'hFFFF_FFFF, 16'd2,  5,  0, 5);
    add_vec(32'h1234_5678, 32'h0001_0000, 32'h8000_0000, 16'd0,  4,  0, 4);
    for (int r = 0; r < 6; r++) begin
      logic [15:0] rp;
      rp = 16'($urandom_range(0, 5));
      add_vec($urandom, $urandom >> 4, $urandom, rp, int'($urandom_range(1, 12)),
              1'($urandom_range(0, 1)), ((rp == 16'd0) ? 1 : int'(rp)) + 3);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      run_sweep(vecs[i]);
      if (i == 0) begin
        // Quarter-turn increment: fixed four-sample pattern
        chk("quad_count", longint'(got_q.size()), 8);
        for (int s = 0; s < 8 && s < got_q.size(); s++)
          chk("quad_value", longint'(got_q[s]), longint'(sq_exp[s % 4]));
      end
    end

    // Reset in the middle of a P=4 sweep
    @(negedge clk);
    fstart = 32'h1000_0000; fstep = 32'h0010_0000; fstop = 32'hFFFF_FFFF;
    per = 16'd4; start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    pre_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (nd) pre_cnt++;
    end
    chk("pre_reset_strobes", longint'(pre_cnt), 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_data", longint'(data), 0);
    chk("midrst_nd", longint'(nd), 0);
    chk("midrst_busy", longint'(busy), 0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("post_rst_nd", longint'(nd), 0);
      chk("post_rst_busy", longint'(busy), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
